// File: rtl/inst_encoding.sv
// Instruction encoder and instruction-memory writer: packs field sets into R/I/J words,
// buffers them in a FIFO and streams them to memory. Optional macro: INST_JCHECK_EN.
module inst_encoding #(
  parameter int          FIFO_DEPTH = 4,
  parameter int          ADDR_W     = 8,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        opcode,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  input  logic [15:0]       immediate,
  input  logic [25:0]       address,
  input  logic              flush,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  input  logic              wr_ready,
  output logic [ADDR_W:0]   count,
  output logic              err
);

  localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0]    DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0]   CNT_MAX = '1;
  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

  function automatic logic is_jtype(input logic [5:0] op);
    return (op == 6'h02) || (op == 6'h07);
  endfunction

  function automatic logic [31:0] encode_word(
    input logic [5:0]  op,
    input logic [4:0]  f_rs,
    input logic [4:0]  f_rt,
    input logic [4:0]  f_rd,
    input logic [4:0]  f_sh,
    input logic [5:0]  f_fn,
    input logic [15:0] f_imm,
    input logic [25:0] f_addr
  );
    logic [31:0] w;
    case (op)
      6'h03:        w = {op, f_rs, f_rt, f_rd, f_sh, f_fn};
      6'h02, 6'h07: w = {op, f_addr};
      default:      w = {op, f_rs, f_rt, f_imm};
    endcase
    return w;
  endfunction

  logic [31:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [PTR_W:0]    occ_q, occ_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              err_q, err_d;

  logic              full_s, empty_s, accept_s, reject_s, push_s, pop_s;
  logic [31:0]       word_s;

  assign full_s   = (occ_q == DEPTH_C);
  assign empty_s  = (occ_q == '0);
  assign in_ready = ~full_s;
  assign wr_en    = ~empty_s;
  assign wr_data  = empty_s ? 32'h0 : mem_q[rptr_q];
  assign wr_addr  = addr_q;
  assign count    = cnt_q;
  assign err      = err_q;

  // Handshake qualification: flush suppresses both push and pop in its cycle
  always_comb begin
    accept_s = in_valid & ~full_s;
`ifdef INST_JCHECK_EN
    reject_s = accept_s & is_jtype(opcode) & ((address >> ADDR_W) != 26'h0);
`else
    reject_s = 1'b0;
`endif
    push_s = accept_s & ~reject_s & ~flush;
    pop_s  = ~empty_s & wr_ready & ~flush;
    word_s = encode_word(opcode, rs, rt, rd, shamt, funct, immediate, address);
  end

  // Next-state for pointers, occupancy, write address, write count and reject flag
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    occ_d  = occ_q;
    addr_d = addr_q;
    cnt_d  = cnt_q;
    err_d  = reject_s & ~flush;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      occ_d  = '0;
      addr_d = BASE_C;
      cnt_d  = '0;
    end else begin
      if (push_s) begin
        wptr_d = wptr_q + PTR_W'(1);
      end else begin
        wptr_d = wptr_q;
      end
      if (pop_s) begin
        rptr_d = rptr_q + PTR_W'(1);
        addr_d = addr_q + ADDR_W'(1);
        cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + (ADDR_W + 1)'(1);
      end else begin
        rptr_d = rptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   occ_d = occ_q + (PTR_W + 1)'(1);
        2'b01:   occ_d = occ_q - (PTR_W + 1)'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
      addr_q <= BASE_C;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  // FIFO storage; cleared on reset so no stale word is ever observable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 32'h0;
      end
    end else if (push_s) begin
      mem_q[wptr_q] <= word_s;
    end
  end

endmodule

// File: tb/tb_inst_encoding.sv
// Self-checking bench for inst_encoding: directed test-plan scenarios plus randomized
// streams compared against a queue-based reference model.
module tb_inst_encoding;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 8;
`ifdef INST_JCHECK_EN
  localparam bit JCHK = 1'b1;
`else
  localparam bit JCHK = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, flush = 1'b0, wr_ready = 1'b0;
  logic [5:0] opcode = 6'h0, funct = 6'h0;
  logic [4:0] rs = 5'h0, rt = 5'h0, rd = 5'h0, shamt = 5'h0;
  logic [15:0] immediate = 16'h0;
  logic [25:0] address = 26'h0;
  logic in_ready, wr_en, err;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0] wr_data;
  logic [ADDR_W:0] count;

  int n_vec = 0, n_err = 0;

  inst_encoding #(.FIFO_DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .immediate(immediate), .address(address), .flush(flush),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .count(count), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] a, input logic [4:0] b,
                                      input logic [4:0] c, input logic [4:0] s, input logic [5:0] f,
                                      input logic [15:0] imm, input logic [25:0] ad);
    if (op == 6'h03) return {op, a, b, c, s, f};
    else if (op == 6'h02 || op == 6'h07) return {op, ad};
    else return {op, a, b, imm};
  endfunction

  // Reference model: queue of pending words, write address and saturating write count
  logic [31:0] mq[$];
  int m_addr = 0, m_cnt = 0;
  bit m_err = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_addr <= 0;
      m_cnt  <= 0;
      m_err  <= 1'b0;
    end else begin
      automatic int sz  = mq.size();
      automatic bit acc = in_valid && (sz < DEPTH);
      automatic bit wrt = (sz > 0) && wr_ready;
      automatic bit rej = JCHK && (opcode == 6'h02 || opcode == 6'h07) && (int'(address) >= (1 << ADDR_W));
      m_err <= acc && rej && !flush;
      if (flush) begin
        mq.delete();
        m_addr <= 0;
        m_cnt  <= 0;
      end else begin
        if (wrt) begin
          void'(mq.pop_front());
          m_addr <= (m_addr + 1) % (1 << ADDR_W);
          m_cnt  <= (m_cnt < (1 << (ADDR_W + 1)) - 1) ? m_cnt + 1 : m_cnt;
        end
        if (acc && !rej) mq.push_back(enc(opcode, rs, rt, rd, shamt, funct, immediate, address));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [5:0] op, input logic [4:0] a, input logic [4:0] b,
                            input logic [4:0] c, input logic [4:0] s, input logic [5:0] f,
                            input logic [15:0] imm, input logic [25:0] ad);
    opcode = op; rs = a; rt = b; rd = c; shamt = s; funct = f; immediate = imm; address = ad;
  endtask

  task automatic do_flush();
    flush = 1'b1; tick(); flush = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_vec++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en got %b want 0", wr_en); end
    n_vec++; if (wr_addr !== 8'h0) begin n_err++; $display("FAIL reset_wr_addr got %h want 0", wr_addr); end
    n_vec++; if (wr_data !== 32'h0) begin n_err++; $display("FAIL reset_wr_data got %h want 0", wr_data); end
    n_vec++; if (count !== 9'h0 || err !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_misc got count=%0d err=%b in_ready=%b want 0/0/1", count, err, in_ready);
    end
    @(posedge clk); #1; rst_n = 1'b1;
  endtask

  task automatic test_r_format();
    wr_ready = 1'b1;
    set_fields(6'h03, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0);
    in_valid = 1'b1; tick(); in_valid = 1'b0;
    n_vec++; if (wr_en !== 1'b1 || wr_data !== 32'h0C221820 || wr_addr !== 8'd0) begin
      n_err++; $display("FAIL r_word got en=%b data=%h addr=%0d want 1/0c221820/0", wr_en, wr_data, wr_addr);
    end
    tick();
    n_vec++; if (count !== 9'd1 || wr_en !== 1'b0) begin
      n_err++; $display("FAIL r_count got count=%0d en=%b want 1/0", count, wr_en);
    end
  endtask

  task automatic test_i_j_format();
    do_flush();
    wr_ready = 1'b1;
    set_fields(6'h08, 5'd4, 5'd5, 5'd0, 5'd0, 6'h0, 16'hFFFF, 26'h0);
    in_valid = 1'b1; tick();
    n_vec++; if (wr_data !== 32'h2085FFFF || wr_addr !== 8'd0) begin
      n_err++; $display("FAIL i_word got data=%h addr=%0d want 2085ffff/0", wr_data, wr_addr);
    end
    set_fields(6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h10);
    tick(); in_valid = 1'b0;
    n_vec++; if (wr_data !== 32'h08000010 || wr_addr !== 8'd1) begin
      n_err++; $display("FAIL j_word got data=%h addr=%0d want 08000010/1", wr_data, wr_addr);
    end
    tick();
    n_vec++; if (count !== 9'd2 || wr_en !== 1'b0) begin
      n_err++; $display("FAIL ij_count got count=%0d en=%b want 2/0", count, wr_en);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] w [5];
    do_flush();
    wr_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_fields(6'h08, 5'd4, 5'd5, 5'd0, 5'd0, 6'h0, 16'hA000 + 16'(i), 26'h0);
      w[i] = enc(6'h08, 5'd4, 5'd5, 5'd0, 5'd0, 6'h0, 16'hA000 + 16'(i), 26'h0);
      tick();
      n_vec++; if (in_ready !== (i < 3)) begin
        n_err++; $display("FAIL bp_in_ready[%0d] got %b want %b", i, in_ready, (i < 3));
      end
    end
    wr_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_vec++; if (wr_en !== 1'b1 || wr_data !== w[i] || wr_addr !== 8'(i)) begin
        n_err++; $display("FAIL bp_write[%0d] got en=%b data=%h addr=%0d want 1/%h/%0d", i, wr_en, wr_data, wr_addr, w[i], i);
      end
      tick();
      if (i == 1) in_valid = 1'b0;
    end
    n_vec++; if (wr_en !== 1'b0 || count !== 9'd5) begin
      n_err++; $display("FAIL bp_done got en=%b count=%0d want 0/5", wr_en, count);
    end
  endtask

  task automatic test_flush_with_valid();
    wr_ready = 1'b0;
    in_valid = 1'b1;
    set_fields(6'h03, 5'd7, 5'd8, 5'd9, 5'd1, 6'h21, 16'h0, 26'h0);
    tick(); tick();
    flush = 1'b1; wr_ready = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0;
    n_vec++; if (wr_en !== 1'b0 || wr_addr !== 8'd0 || count !== 9'd0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL flush got en=%b addr=%0d count=%0d rdy=%b want 0/0/0/1", wr_en, wr_addr, count, in_ready);
    end
  endtask

  task automatic test_jcheck();
    do_flush();
    wr_ready = 1'b1;
    set_fields(6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h100);
    in_valid = 1'b1; tick(); in_valid = 1'b0;
    n_vec++; if (wr_en !== !JCHK || err !== JCHK) begin
      n_err++; $display("FAIL jchk_far got en=%b err=%b want %b/%b", wr_en, err, !JCHK, JCHK);
    end
    if (!JCHK) begin
      n_vec++; if (wr_data !== 32'h08000100) begin
        n_err++; $display("FAIL jchk_far_data got %h want 08000100", wr_data);
      end
    end
    set_fields(6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'hFF);
    in_valid = 1'b1; tick(); in_valid = 1'b0;
    n_vec++; if (wr_en !== 1'b1 || wr_data !== 32'h080000FF || err !== 1'b0) begin
      n_err++; $display("FAIL jchk_near got en=%b data=%h err=%b want 1/080000ff/0", wr_en, wr_data, err);
    end
    tick();
  endtask

  task automatic test_stream(input int cycles, input bit rnd);
    do_flush();
    for (int c = 0; c < cycles; c++) begin
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      wr_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      flush    = rnd ? ($urandom_range(0, 63) == 0) : 1'b0;
      case ($urandom_range(0, 3))
        0:       opcode = 6'h03;
        1:       opcode = $urandom_range(0, 1) ? 6'h02 : 6'h07;
        default: opcode = 6'($urandom);
      endcase
      {rs, rt, rd, shamt} = 20'($urandom);
      funct = 6'($urandom); immediate = 16'($urandom);
      address = $urandom_range(0, 1) ? 26'($urandom_range(0, 255)) : 26'($urandom);
      tick();
      n_vec++; if (wr_en !== (mq.size() != 0) || wr_data !== ((mq.size() != 0) ? mq[0] : 32'h0)) begin
        n_err++; $display("FAIL stream_head c=%0d got en=%b data=%h want %b/%h", c, wr_en, wr_data,
                          (mq.size() != 0), ((mq.size() != 0) ? mq[0] : 32'h0));
      end
      n_vec++; if (wr_addr !== 8'(m_addr) || count !== 9'(m_cnt) || in_ready !== (mq.size() < DEPTH) || err !== m_err) begin
        n_err++; $display("FAIL stream_state c=%0d got addr=%0d cnt=%0d rdy=%b err=%b want %0d/%0d/%b/%b", c,
                          wr_addr, count, in_ready, err, m_addr, m_cnt, (mq.size() < DEPTH), m_err);
      end
    end
    in_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic test_saturate();
    test_stream(600, 1'b0);
    n_vec++; if (count !== 9'h1FF) begin
      n_err++; $display("FAIL saturate got count=%0d want 511", count);
    end
  endtask

  task automatic test_reset_midstream();
    do_flush();
    wr_ready = 1'b0; in_valid = 1'b1;
    set_fields(6'h03, 5'd1, 5'd1, 5'd1, 5'd1, 6'h1, 16'h0, 26'h0);
    tick(); tick(); tick();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (wr_en !== 1'b0 || wr_addr !== 8'd0 || count !== 9'd0 || wr_data !== 32'h0) begin
      n_err++; $display("FAIL async_reset got en=%b addr=%0d count=%0d data=%h want 0/0/0/0", wr_en, wr_addr, count, wr_data);
    end
    tick(); rst_n = 1'b1; wr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++; if (wr_en !== 1'b0 || count !== 9'd0) begin
        n_err++; $display("FAIL post_reset[%0d] got en=%b count=%0d want 0/0", i, wr_en, count);
      end
    end
  endtask

  initial begin
    test_reset();
    test_r_format();
    test_i_j_format();
    test_backpressure();
    test_flush_with_valid();
    test_jcheck();
    test_stream(1500, 1'b1);
    test_saturate();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
